int_seq_counter: RTL and testbench



---
 rtl/int_seq_counter.sv | 71 +++++++
 tb/tb_int_seq_counter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_seq_counter.sv
// Microcode step counter with terminal count, plus interrupt request latches
// gated by a global enable latch. Everything is registered except tc and req_masked.
module int_seq_counter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_clr,
    input  logic             write,
    input  logic             tick,
    input  logic             countdown,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    input  logic [NREQ-1:0]  req_set,
    input  logic [NREQ-1:0]  req_clr,
    input  logic             en_set,
    input  logic             en_clr,
    output logic [NREQ-1:0]  req_latched,
    output logic [NREQ-1:0]  req_masked,
    output logic             en
);

    logic [WIDTH-1:0] cnt_next;
    logic [NREQ-1:0]  req_next;
    logic             en_next;

    // Clear beats load beats count; direction only matters while ticking.
    always_comb begin
        cnt_next = out;
        if (cnt_clr) begin
            cnt_next = '0;
        end else if (write) begin
            cnt_next = in;
        end else if (tick) begin
            if (countdown) begin
                cnt_next = out - WIDTH'(1);
            end else begin
                cnt_next = out + WIDTH'(1);
            end
        end
    end

    // Set dominates clear so a fresh request is never dropped; disable dominates enable.
    always_comb begin
        req_next = req_set | (req_latched & ~req_clr);
        en_next  = en;
        if (en_clr) begin
            en_next = 1'b0;
        end else if (en_set) begin
            en_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out         <= '0;
            req_latched <= '0;
            en          <= 1'b1;
        end else begin
            out         <= cnt_next;
            req_latched <= req_next;
            en          <= en_next;
        end
    end

    assign tc         = countdown ? (out == '0) : (out == '1);
    assign req_masked = req_latched & {NREQ{en}};

endmodule

// File: tb/tb_int_seq_counter.sv
// Self-checking bench for int_seq_counter: directed scenarios plus randomized
// traffic compared against an arithmetic reference model.
module tb_int_seq_counter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 5;
    localparam int MOD   = 1 << WIDTH;

    logic             clk;
    logic             rst;
    logic             cnt_clr;
    logic             write;
    logic             tick;
    logic             countdown;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic [NREQ-1:0]  req_set;
    logic [NREQ-1:0]  req_clr;
    logic             en_set;
    logic             en_clr;
    logic [NREQ-1:0]  req_latched;
    logic [NREQ-1:0]  req_masked;
    logic             en;

    int               errors;
    int               checks;

    // Reference model state
    int               m_cnt;
    logic [NREQ-1:0]  m_req;
    logic             m_en;

    int_seq_counter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_clr    (cnt_clr),
        .write      (write),
        .tick       (tick),
        .countdown  (countdown),
        .in         (in),
        .out        (out),
        .tc         (tc),
        .req_set    (req_set),
        .req_clr    (req_clr),
        .en_set     (en_set),
        .en_clr     (en_clr),
        .req_latched(req_latched),
        .req_masked (req_masked),
        .en         (en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_tc();
        if (countdown) return (m_cnt == 0);
        return (m_cnt == MOD - 1);
    endfunction

    function automatic logic [NREQ-1:0] model_masked();
        return m_en ? m_req : '0;
    endfunction

    task automatic idle_inputs();
        cnt_clr   = 1'b0;
        write     = 1'b0;
        tick      = 1'b0;
        countdown = 1'b0;
        in        = '0;
        req_set   = '0;
        req_clr   = '0;
        en_set    = 1'b0;
        en_clr    = 1'b0;
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_req = '0;
        m_en  = 1'b1;
    endtask

    // One clock edge; model advances from the inputs present at the edge.
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            if (cnt_clr)       m_cnt = 0;
            else if (write)    m_cnt = int'(in);
            else if (tick)     m_cnt = countdown ? (m_cnt + MOD - 1) % MOD : (m_cnt + 1) % MOD;
            for (int i = 0; i < NREQ; i++) begin
                if (req_set[i])      m_req[i] = 1'b1;
                else if (req_clr[i]) m_req[i] = 1'b0;
            end
            if (en_clr)      m_en = 1'b0;
            else if (en_set) m_en = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        // Come out of power-on reset first
        idle_inputs();
        rst = 1'b0;
        model_reset();
        repeat (3) cycle();
        checks++;
        if (out !== 4'd0 || req_latched !== 5'b0 || en !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: out=%0d req=%b en=%b, want out=0 req=0 en=1", out, req_latched, en);
        end
        rst = 1'b1;
        // Build state: out=7, requests 10101, en=0
        write = 1'b1; in = 4'd7; req_set = 5'b10101; en_clr = 1'b1;
        cycle();
        idle_inputs();
        checks++;
        if (out !== 4'd7 || req_latched !== 5'b10101 || en !== 1'b0) begin
            errors++;
            $display("FAIL reset_setup: out=%0d req=%b en=%b, want 7 10101 0", out, req_latched, en);
        end
        // Asynchronous assertion mid-cycle, checked before any clock edge
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (out !== 4'd0 || req_latched !== 5'b0 || en !== 1'b1 || tc !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: out=%0d req=%b en=%b tc=%b, want 0 00000 1 0", out, req_latched, en, tc);
        end
        countdown = 1'b1;
        #1;
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL reset_tc_down: tc=%b, want 1", tc);
        end
        countdown = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_count_up();
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        tick = 1'b1;
        countdown = 1'b0;
        for (int i = 0; i < 17; i++) begin
            cycle();
            checks++;
            if (out !== WIDTH'((i + 1) % MOD) || tc !== ((i + 1) % MOD == MOD - 1)) begin
                errors++;
                $display("FAIL count_up[%0d]: out=%0d tc=%b, want out=%0d tc=%b", i, out, tc,
                         (i + 1) % MOD, ((i + 1) % MOD == MOD - 1));
            end
        end
        idle_inputs();
    endtask

    task automatic test_count_down();
        logic [WIDTH-1:0] exp_seq [3];
        exp_seq[0] = 4'h1; exp_seq[1] = 4'h0; exp_seq[2] = 4'hF;
        write = 1'b1; in = 4'h2; tick = 1'b1;
        cycle();
        checks++;
        if (out !== 4'h2) begin
            errors++;
            $display("FAIL load_over_tick: out=%h, want 2", out);
        end
        write = 1'b0; countdown = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (out !== exp_seq[i] || tc !== (exp_seq[i] == 4'h0)) begin
                errors++;
                $display("FAIL count_down[%0d]: out=%h tc=%b, want out=%h tc=%b", i, out, tc,
                         exp_seq[i], (exp_seq[i] == 4'h0));
            end
        end
        tick = 1'b0;
        cnt_clr = 1'b1; write = 1'b1; in = 4'd9;
        cycle();
        checks++;
        if (out !== 4'd0) begin
            errors++;
            $display("FAIL clr_over_write: out=%0d, want 0", out);
        end
        idle_inputs();
        // tc ignores tick: counter at 0, not ticking, countdown=1
        countdown = 1'b1;
        #1;
        checks++;
        if (tc !== 1'b1 || out !== 4'd0) begin
            errors++;
            $display("FAIL tc_no_tick: tc=%b out=%0d, want tc=1 out=0", tc, out);
        end
        countdown = 1'b0;
    endtask

    task automatic test_req_latch();
        req_set = 5'b00010;
        cycle();
        req_set = '0;
        cycle();
        checks++;
        if (req_latched !== 5'b00010) begin
            errors++;
            $display("FAIL req_pulse: req_latched=%b, want 00010", req_latched);
        end
        req_set = 5'b00010; req_clr = 5'b00010;
        cycle();
        checks++;
        if (req_latched !== 5'b00010) begin
            errors++;
            $display("FAIL req_set_wins: req_latched=%b, want 00010", req_latched);
        end
        req_set = '0;
        cycle();
        checks++;
        if (req_latched !== 5'b00000) begin
            errors++;
            $display("FAIL req_clear: req_latched=%b, want 00000", req_latched);
        end
        req_clr = '0;
    endtask

    task automatic test_masking();
        req_set = 5'b01001;
        cycle();
        req_set = '0;
        checks++;
        if (req_masked !== 5'b01001 || en !== 1'b1) begin
            errors++;
            $display("FAIL mask_en1: req_masked=%b en=%b, want 01001 1", req_masked, en);
        end
        en_clr = 1'b1;
        cycle();
        en_clr = 1'b0;
        checks++;
        if (req_masked !== 5'b0 || req_latched !== 5'b01001 || en !== 1'b0) begin
            errors++;
            $display("FAIL mask_en0: masked=%b latched=%b en=%b, want 00000 01001 0",
                     req_masked, req_latched, en);
        end
        en_set = 1'b1; en_clr = 1'b1;
        cycle();
        checks++;
        if (en !== 1'b0 || req_masked !== 5'b0) begin
            errors++;
            $display("FAIL en_clr_wins: en=%b masked=%b, want 0 00000", en, req_masked);
        end
        en_clr = 1'b0;
        cycle();
        en_set = 1'b0;
        checks++;
        if (en !== 1'b1 || req_masked !== 5'b01001) begin
            errors++;
            $display("FAIL mask_restore: en=%b masked=%b, want 1 01001", en, req_masked);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cnt_clr   = ($urandom_range(0, 15) == 0);
            write     = ($urandom_range(0, 7) == 0);
            tick      = $urandom_range(0, 1);
            countdown = $urandom_range(0, 1);
            in        = WIDTH'($urandom);
            req_set   = NREQ'($urandom) & NREQ'($urandom);
            req_clr   = NREQ'($urandom);
            en_set    = $urandom_range(0, 1);
            en_clr    = ($urandom_range(0, 3) == 0);
            cycle();
            checks++;
            if (int'(out) !== m_cnt || tc !== model_tc()) begin
                errors++;
                $display("FAIL rand_cnt[%0d]: out=%0d tc=%b, want out=%0d tc=%b", n, out, tc, m_cnt, model_tc());
            end
            checks++;
            if (req_latched !== m_req || req_masked !== model_masked() || en !== m_en) begin
                errors++;
                $display("FAIL rand_req[%0d]: latched=%b masked=%b en=%b, want %b %b %b", n,
                         req_latched, req_masked, en, m_req, model_masked(), m_en);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_release();
        write = 1'b1; in = 4'd11; req_set = 5'b11100;
        cycle();
        idle_inputs();
        #2;
        rst = 1'b0;
        model_reset();
        req_set = 5'b11111;
        tick = 1'b1;
        cycle();
        checks++;
        if (out !== 4'd0 || req_latched !== 5'b0 || en !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold_reqs: out=%0d req=%b en=%b, want 0 00000 1", out, req_latched, en);
        end
        req_set = '0;
        rst = 1'b1;
        cycle();
        checks++;
        if (out !== 4'd1 || req_latched !== 5'b0 || req_masked !== 5'b0 || en !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: out=%0d req=%b masked=%b en=%b, want 1 00000 00000 1",
                     out, req_latched, req_masked, en);
        end
        idle_inputs();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_count_up();
        test_count_down();
        test_req_latch();
        test_masking();
        test_random();
        test_reset_release();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
